uart_receiver: RTL and testbench
================================

# uart_receiver

Serial receive path paired with the board's UART transmitter, on the same 27 MHz clock and 115200 baud frame timing. Synchronises the asynchronous `uart_rx` pin, detects and qualifies start bits, samples 8N1 frames at bit centres, and buffers received bytes in a small FIFO. Downstream logic drains the FIFO through a valid/ready handshake.

## Interface
- `DELAY_FRAMES`, 234: clocks per bit (27,000,000 / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 4: byte entries; power of two, ≥ 2.
- `clk`  in  1  system clock, 27 MHz.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `rx_data`  out  8  head-of-FIFO byte; reads 0 when `rx_valid`=0.
- `rx_valid`  out  1  FIFO non-empty.
- `rx_ready`  in  1  consumer accepts; pop on `rx_valid && rx_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: good byte dropped, FIFO full.

## Operation
- Input synchroniser: two flops, both reset to 1. `rx_s` is the second flop output. All decisions use `rx_s` only.
- `HALF = DELAY_FRAMES/2` (integer division). Bit counter width is `$clog2(DELAY_FRAMES)`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- **IDLE**
  - On `rx_s`=0: go to START, counter←0.
- **START**
  - When counter+1 == HALF, re-sample. `rx_s`=0 → DATA, counter←0, bit index←0.
  - `rx_s`=1 → glitch: return to IDLE with no output.
- **DATA**
  - When counter+1 == DELAY_FRAMES: shift in LSB-first (`shift ← {rx_s, shift[7:1]}`) and set counter←0.
  - Bit index 7 → STOP; otherwise increment the index.
- **STOP**
  - When counter+1 == DELAY_FRAMES, sample `rx_s`.
  - `rx_s`=1 and FIFO not full → push `shift`, go to IDLE.
  - `rx_s`=1 and FIFO full → `overrun` pulse, byte discarded, go to IDLE.
  - Exception: FIFO full with a pop in the same cycle → push accepted, no overrun.
  - `rx_s`=0 → `frame_err` pulse, byte discarded, go to BREAK.
- **BREAK**
  - Wait for `rx_s`=1, then go to IDLE. A held-low line never produces bytes.
- The FSM returns to IDLE at mid-stop-bit, so back-to-back frames with one stop bit are received.
- **FIFO**
  - `count` range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle: count unchanged. Pop while empty is impossible (`rx_valid` gates it).
- **Reset**
  - Effect: FSM→IDLE; counters, bit index, shift and pointers→0; FIFO empty.
  - Output values: `rx_valid`=0, `rx_data`=0, `frame_err`=0, `overrun`=0.
  - Reset mid-frame abandons the frame. If the line is still low on exit, the next `rx_s`=0 is treated as a start bit (rejected at the START re-sample only if high).

## Timing
- S = first cycle `rx_s` reads 0. Pin-to-`rx_s` latency is 2 cycles.
- Start re-sample at S+HALF. Data bit k sampled at S+HALF+(k+1)·DELAY_FRAMES.
- Stop sampled at S+HALF+9·DELAY_FRAMES. With defaults: S+117, S+351 … S+1989, stop at S+2223.
- `rx_valid` rises the cycle after the push (S+2224 with defaults).
- `rx_data` is stable while `rx_valid`=1 and no pop occurs.
- After a pop, `rx_data`/`rx_valid` reflect the new head on the next cycle.
- `frame_err`/`overrun` are high for exactly one cycle, the cycle after the stop sample.

## Structure
- Package `uart_pkg` holds:
  - FSM state encoding (5 states, 3 bits);
  - default `DELAY_FRAMES` (234) and 8-bit data width.
- The transmitter uses the same package.
- One sub-module: `uart_rx_fifo` (parameter `FIFO_DEPTH`, 8-bit data).
  - Ports: push/pop/full/empty; register-based storage with combinational head read.
- Frame FSM, synchroniser and bit timing remain in `uart_receiver`.

## Test plan
- Frame 0x55 at DELAY_FRAMES=234, `rx_ready`=1 → `rx_valid` for 1 cycle at S+2224, `rx_data`=0x55, no error pulses.
- Back-to-back 0x4C, 0x75, 0x0A, one stop bit each, `rx_ready`=0 → count=3; drain yields 0x4C, 0x75, 0x0A in order.
- 50-cycle low glitch on idle line → no push, FSM back to IDLE at S+HALF; a following valid 0xA3 is received correctly.
- Frame 0xFF with stop bit driven low, line low for 1000 cycles → single `frame_err` pulse, nothing pushed, no further activity until line high.
- `rx_ready`=0, send 5 bytes with FIFO_DEPTH=4 → first 4 retained, one `overrun` pulse on 5th; repeat with pop on 5th stop-sample cycle → no overrun, 5th byte stored.
- Assert `rst` for 1 cycle at mid-DATA of frame 0x3C → outputs at reset values next cycle, FIFO empty; next full frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receive FSM state encoding
package uart_pkg;

  localparam int DELAY_FRAMES_DEF = 234;
  localparam int DATA_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - register-based byte FIFO with combinational head read
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive path: synchroniser, frame FSM, byte FIFO
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = DELAY_FRAMES_DEF,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int HALF  = DELAY_FRAMES / 2;
  localparam int CNT_W = $clog2(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DELAY_FRAMES - 1);

  logic              sync1_q, sync1_d;
  logic              rx_s_q, rx_s_d;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;

  logic              half_tick;
  logic              bit_tick;
  logic              stop_good;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign sync1_d   = uart_rx;
  assign rx_s_d    = sync1_q;
  assign half_tick = (cnt_q == HALF_LAST);
  assign bit_tick  = (cnt_q == BIT_LAST);
  assign rx_valid  = !fifo_empty;
  assign pop       = rx_valid && rx_ready;
  assign stop_good = (state_q == ST_STOP) && bit_tick && rx_s_q;
  // A full FIFO still accepts the byte when the consumer frees a slot this cycle.
  assign push      = stop_good && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!rx_s_q) state_d = ST_START;
      ST_START: if (half_tick) state_d = rx_s_q ? ST_IDLE : ST_DATA;
      ST_DATA:  if (bit_tick && (bit_idx_q == 3'd7)) state_d = ST_STOP;
      ST_STOP:  if (bit_tick) state_d = rx_s_q ? ST_IDLE : ST_BREAK;
      ST_BREAK: if (rx_s_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    case (state_q)
      ST_IDLE: cnt_d = '0;
      ST_START: begin
        if (half_tick) begin
          cnt_d     = '0;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[DATA_W-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          cnt_d       = '0;
          frame_err_d = !rx_s_q;
          overrun_d   = rx_s_q && fifo_full && !pop;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: cnt_d = '0;
      default:  cnt_d = '0;
    endcase
  end

  uart_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(shift_q),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_data(fifo_head)
  );

  assign rx_data   = rx_valid ? fifo_head : '0;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - self-checking bench for uart_receiver
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int D     = DELAY_FRAMES_DEF;
  localparam int DEPTH = 4;
  localparam int HALF  = D / 2;
  // Pin edge to first registered output: 2 sync cycles, start+9 bit periods, 1 register.
  localparam int OUT_LAT = 2 + HALF + 9 * D + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              uart_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              overrun;

  always #5 clk = ~clk;

  uart_receiver #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_p = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int model_cnt = 0;
  int exp_fe = 0, exp_ov = 0;
  int fe_cnt = 0, ov_cnt = 0, fe_last = -1, ov_last = -1;
  int valid_rise = -1, valid_hi = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) begin fe_cnt++; fe_last = cyc; end
    if (overrun) begin ov_cnt++; ov_last = cyc; end
    if (rx_valid && !prev_valid) valid_rise = cyc;
    if (rx_valid) valid_hi++;
    prev_valid = rx_valid;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: accept a good frame while the queue has room (or a slot frees the same cycle).
  task automatic model_frame(input logic [7:0] b, input logic stop, input logic pop_same);
    if (!stop) exp_fe++;
    else if (model_cnt < DEPTH || pop_same) begin
      exp_q.push_back(b);
      if (!pop_same) model_cnt++;
    end else exp_ov++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_p  = cyc;
    uart_rx = 1'b0;
    wait_cycles(D);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(D);
    end
    uart_rx = stop;
    wait_cycles(D);
    if (stop) uart_rx = 1'b1;
  endtask

  task automatic drain(input string name);
    int guard = 0;
    rx_ready = 1'b1;
    while (rx_valid && guard < 4 * DEPTH) begin
      wait_cycles(1);
      guard++;
    end
    rx_ready = 1'b0;
    model_cnt = 0;
    n_cmp++;
    if (got_q.size() != exp_q.size() || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_count: got %0d bytes (valid=%b) expected %0d bytes", name, got_q.size(), rx_valid, exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s_byte%0d: got %h expected %h", name, i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_errs(input string name);
    n_cmp++;
    if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
      n_fail++;
      $display("FAIL %s_errs: got fe=%0d ov=%0d expected fe=%0d ov=%0d", name, fe_cnt, ov_cnt, exp_fe, exp_ov);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);
    n_cmp++;
    if ({rx_valid, rx_data, frame_err, overrun} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h fe=%b ov=%b expected all 0", rx_valid, rx_data, frame_err, overrun);
    end
  endtask

  task automatic test_single();
    int hi0;
    rx_ready = 1'b1;
    hi0 = valid_hi;
    send_byte(8'h55, 1'b1);
    model_frame(8'h55, 1'b1, 1'b0);
    wait_cycles(20);
    n_cmp++;
    if (valid_rise !== last_p + OUT_LAT) begin
      n_fail++;
      $display("FAIL single_latency: got rise cycle %0d expected %0d", valid_rise, last_p + OUT_LAT);
    end
    n_cmp++;
    if (valid_hi - hi0 !== 1) begin
      n_fail++;
      $display("FAIL single_valid_width: got %0d cycles expected 1", valid_hi - hi0);
    end
    n_cmp++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL single_data_idle: got %h expected 00", rx_data);
    end
    drain("single");
    check_errs("single");
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [3];
    seq = '{8'h4C, 8'h75, 8'h0A};
    rx_ready = 1'b0;
    foreach (seq[i]) begin
      send_byte(seq[i], 1'b1);
      model_frame(seq[i], 1'b1, 1'b0);
    end
    wait_cycles(5);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h4C) begin
      n_fail++;
      $display("FAIL b2b_head: got valid=%b data=%h expected 1/4c", rx_valid, rx_data);
    end
    drain("b2b");
    check_errs("b2b");
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    uart_rx = 1'b0;
    wait_cycles(50);
    uart_rx = 1'b1;
    wait_cycles(2 * D);
    send_byte(8'hA3, 1'b1);
    model_frame(8'hA3, 1'b1, 1'b0);
    wait_cycles(20);
    drain("glitch");
    check_errs("glitch");
  endtask

  task automatic test_break();
    rx_ready = 1'b1;
    send_byte(8'hFF, 1'b0);
    model_frame(8'hFF, 1'b0, 1'b0);
    wait_cycles(1000);
    uart_rx = 1'b1;
    wait_cycles(D);
    n_cmp++;
    if (fe_last !== last_p + OUT_LAT) begin
      n_fail++;
      $display("FAIL break_fe_time: got cycle %0d expected %0d", fe_last, last_p + OUT_LAT);
    end
    drain("break");
    check_errs("break");
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_frame(b, 1'b1, 1'b0);
    end
    n_cmp++;
    if (ov_last !== last_p + OUT_LAT) begin
      n_fail++;
      $display("FAIL overrun_time: got cycle %0d expected %0d", ov_last, last_p + OUT_LAT);
    end
    check_errs("overrun");
    drain("overrun");
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1);
      model_frame(b, 1'b1, 1'b0);
    end
    b = 8'($urandom);
    fork
      send_byte(b, 1'b1);
      begin
        wait_cycles(1);
        repeat (last_p + OUT_LAT - 1 - cyc) @(posedge clk);
        #1;
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
      end
    join
    model_frame(b, 1'b1, 1'b1);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== exp_q[1]) begin
      n_fail++;
      $display("FAIL pop_same_head: got valid=%b data=%h expected 1/%h", rx_valid, rx_data, exp_q[1]);
    end
    check_errs("pop_same");
    drain("pop_same");
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    rx_ready = 1'b0;
    b = 8'($urandom);
    send_byte(b, 1'b1);
    model_frame(b, 1'b1, 1'b0);
    uart_rx = 1'b0;
    wait_cycles(D);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 8'h3C >> i;
      wait_cycles(D);
    end
    uart_rx = 1'b1;
    wait_cycles(HALF);
    n_cmp++;
    if (rx_valid !== 1'b1 || rx_data !== b) begin
      n_fail++;
      $display("FAIL pre_reset_head: got valid=%b data=%h expected 1/%h", rx_valid, rx_data, b);
    end
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    n_cmp++;
    if ({rx_valid, rx_data, frame_err, overrun} !== 11'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got valid=%b data=%h fe=%b ov=%b expected all 0", rx_valid, rx_data, frame_err, overrun);
    end
    wait_cycles(2 * D);
    send_byte(8'h81, 1'b1);
    model_frame(8'h81, 1'b1, 1'b0);
    wait_cycles(5);
    drain("mid_reset");
    check_errs("mid_reset");
  endtask

  task automatic test_random();
    logic [7:0] b;
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      wait_cycles($urandom_range(0, 40));
      send_byte(b, 1'b1);
      model_frame(b, 1'b1, 1'b0);
    end
    drain("random");
    check_errs("random");
  endtask

  initial begin
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_overrun();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
